// File: rtl/loader_pkg.sv
// Shared types and stream-format constants for the boot-time program loader.
// Stream: 2-byte word count (high byte first), then big-endian words (first byte -> bits 31:24).
package loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_WORD,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   localparam int unsigned HDR_BYTES      = 2;
   localparam int unsigned BYTES_PER_WORD = 4;

   // States in which the loader consumes a stream byte.
   function automatic logic is_accept_state(input state_t s);
      return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_WORD);
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Byte-to-word shift register: bytes enter at the LSB end, so the first byte
// of a word ends up in the most significant position.
module byte_packer
   import loader_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             shift,
   input  logic [7:0]       in_byte,
   output logic [WIDTH-1:0] word,
   output logic             full
);

   logic [1:0] byte_cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         word     <= '0;
         byte_cnt <= '0;
      end else if (shift) begin
         word     <= {word[WIDTH-9:0], in_byte};
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

   // High in the cycle the last byte of a word is being shifted in.
   assign full = shift && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes packed words into
// instruction memory from BASE_ADDR, and holds the core in reset until done.
module program_loader
   import loader_pkg::*;
#(
   parameter int unsigned              ADD_INST_SIZE = 32,
   parameter int unsigned              SIZE_DATA     = 32,
   parameter int unsigned              MAX_WORDS     = 256,
   parameter logic [ADD_INST_SIZE-1:0] BASE_ADDR     = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_start,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   output logic                     in_ready,
   output logic                     mem_we,
   output logic [ADD_INST_SIZE-1:0] mem_addr,
   output logic [SIZE_DATA-1:0]     mem_wdata,
   output logic                     core_reset,
   output logic                     done,
   output logic                     error
);

   localparam int unsigned IDX_W = $clog2(MAX_WORDS) + 1;

   state_t                   state, state_next;
   logic [7:0]               count_hi;
   logic [15:0]              count_q;
   logic [IDX_W-1:0]         word_idx;
   logic [ADD_INST_SIZE-1:0] addr_q;
   logic                     accept;
   logic                     pack_clear;
   logic                     pack_shift;
   logic                     pack_full;
   logic [16:0]              hdr_len;
   logic                     last_word;

   assign in_ready   = is_accept_state(state);
   assign accept     = in_valid && in_ready;
   assign mem_we     = (state == S_WRITE);
   assign mem_addr   = addr_q;
   assign core_reset = (state != S_DONE);
   assign done       = (state == S_DONE);
   assign error      = (state == S_ERROR);

   assign hdr_len    = {1'b0, count_hi, in_data};
   assign last_word  = (17'(word_idx) + 17'd1) == {1'b0, count_q};
   assign pack_clear = (state == S_LEN_LO);
   assign pack_shift = accept && (state == S_WORD);

   byte_packer #(
      .WIDTH (SIZE_DATA)
   ) u_packer (
      .clk     (clk),
      .reset   (reset),
      .clear   (pack_clear),
      .shift   (pack_shift),
      .in_byte (in_data),
      .word    (mem_wdata),
      .full    (pack_full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (load_start) state_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (accept) state_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (accept) begin
               if (hdr_len == 17'd0)                 state_next = S_DONE;
               else if (hdr_len > 17'(MAX_WORDS))    state_next = S_ERROR;
               else                                  state_next = S_WORD;
            end
         end
         S_WORD: begin
            if (pack_full) state_next = S_WRITE;
         end
         S_WRITE: begin
            state_next = last_word ? S_DONE : S_WORD;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Address is tracked incrementally so it is a plain register at the port.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_hi <= '0;
         count_q  <= '0;
         word_idx <= '0;
         addr_q   <= BASE_ADDR;
      end else begin
         unique case (state)
            S_LEN_HI: begin
               if (accept) count_hi <= in_data;
            end
            S_LEN_LO: begin
               if (accept) begin
                  count_q  <= {count_hi, in_data};
                  word_idx <= '0;
                  addr_q   <= BASE_ADDR;
               end
            end
            S_WRITE: begin
               word_idx <= word_idx + 1'b1;
               addr_q   <= addr_q + ADD_INST_SIZE'(BYTES_PER_WORD);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader sitting directly upstream of the MIPS32 pipeline core's instruction memory. It accepts a byte stream (length header plus big-endian instruction words), packs bytes into 32-bit words and writes them sequentially into instruction memory. It holds the core's PC reset asserted until the load completes, then releases it so fetch starts at `BASE_ADDR`.

## Interface
Parameters:
- `ADD_INST_SIZE`, 32, instruction-memory address width (byte addressing)
- `SIZE_DATA`, 32, instruction word width
- `MAX_WORDS`, 256, instruction-memory depth in words; larger loads are rejected
- `BASE_ADDR`, 32'h0, byte address of the first word written

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `load_start`  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR
- `in_valid`  in  1  byte on `in_data` is valid
- `in_data`  in  8  stream byte
- `in_ready`  out  1  loader accepts a byte this cycle when `in_valid & in_ready`
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word
- `mem_addr`  out  ADD_INST_SIZE  byte address of the word being written
- `mem_wdata`  out  SIZE_DATA  word being written
- `core_reset`  out  1  drives the core's PC `reset`; high except in DONE
- `done`  out  1  load finished successfully
- `error`  out  1  header word count exceeded `MAX_WORDS`

## Operation
- Stream format: 2-byte word count N (high byte first), then 4·N bytes, each word big-endian; the first byte lands in bits 31:24.
- States: IDLE, LEN_HI, LEN_LO, WORD, WRITE, DONE, ERROR.
- IDLE: `in_ready`=0; `load_start` -> LEN_HI.
- LEN_HI: accept a byte into count[15:8] -> LEN_LO.
- LEN_LO: accept a byte into count[7:0]. N=0 -> DONE; N>MAX_WORDS -> ERROR; otherwise -> WORD with word_idx=0 and byte_cnt=0.
- WORD: each accepted byte shifts into the packing register (`word = {word[23:0], byte}`) and increments byte_cnt. The 4th byte -> WRITE.
- WRITE: `mem_we`=1, `mem_addr`=BASE_ADDR + 4·word_idx, `mem_wdata`=packed word, `in_ready`=0. Then word_idx increments. If word_idx+1 == N -> DONE, else -> WORD.
- DONE: `done`=1, `core_reset`=0. `load_start` -> LEN_HI and re-asserts `core_reset` the next cycle.
- ERROR: `error`=1, `core_reset`=1, no memory writes. `load_start` -> LEN_HI.
- `load_start` is ignored in LEN_HI, LEN_LO, WORD and WRITE.
- `in_valid` with `in_ready`=0 is not consumed. The source must hold the byte.
- Address arithmetic is modulo 2^ADD_INST_SIZE. word_idx width is clog2(MAX_WORDS)+1.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0, `core_reset`=1, `done`=0, `error`=0. Internal counters are cleared.
- Reset mid-load aborts to IDLE. Words already written stay in memory, and `core_reset` stays high.
- All outputs are registered or decoded from state only. `in_ready` has no combinational path from `in_valid`.
- `in_ready`=1 exactly in LEN_HI, LEN_LO and WORD. At most one byte is accepted per cycle.
- Byte-to-write latency: the `mem_we` cycle immediately follows the cycle the 4th byte is accepted.
- Per-word throughput: 5 cycles with a continuous stream (4 accept cycles plus 1 WRITE cycle).
- `core_reset` falls on the cycle DONE is entered, which is the cycle after the last WRITE or after LEN_LO when N=0. The core's first fetch is therefore from BASE_ADDR on the following edge.
- `done` and `error` are levels held until the next `load_start` or `reset`.

## Structure
- Shared package `loader_pkg`:
  - state enum
  - `HDR_BYTES=2` and `BYTES_PER_WORD=4`
  - the stream-format byte-order note
- Sub-module `byte_packer`: 8-to-32 shift register with a 2-bit byte counter, `clear` and `shift` inputs, and outputs `word` and `full`. The FSM lives in `program_loader`.

## Test plan
- N=2, bytes 00 02 20 08 00 05 AC 01 00 00 sent back-to-back:
  - `mem_we` pulses twice: addr 0x0 / data 0x20080005, then addr 0x4 / data 0xAC010000.
  - `core_reset` falls the cycle after the 2nd write and `done`=1.
- Same stream with `in_valid` toggled every other cycle: identical writes, no byte lost or duplicated, and `in_ready`=0 during each WRITE.
- Header N=0 (00 00): no `mem_we`; DONE entered the cycle after LEN_LO; `core_reset`=0.
- Header N=MAX_WORDS+1 (01 01 with MAX_WORDS=256): `error`=1, `core_reset`=1, no writes. A following `load_start` plus a valid N=1 stream produces a write to 0x0 and then `done`.
- `reset` asserted after the 2nd byte of word 1: next cycle shows state IDLE, all outputs at reset values, and `load_start` ignored until after reset.
- `load_start` pulsed during WORD: no effect. `load_start` pulsed in DONE: `core_reset` re-asserted and a second load overwrites address 0x0.
